// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB register-array slave.
//   apb_state_e : bus FSM state (IDLE / ACCESS)
//   APB_OKAY / APB_SLVERR : PSLVERR encodings
//   lane_shift(): number of byte-address bits covered by one data word
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;

    // Byte-address bits below the word index: log2(DATA_W/8).
    function automatic int lane_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// ---------------------------------------------------------------------------
// apb_slave_mem_if
// APB bus bundle between a master and apb_slave_mem.
//   psel, pen, paddr, pwrite, pwdata, pstrb : master -> slave
//   prdata, pready, pslverr                 : slave  -> master
// Modports: master, slave.
// ---------------------------------------------------------------------------
interface apb_slave_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  pen;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, pen, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, pen, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regfile.sv
// ---------------------------------------------------------------------------
// apb_regfile
// DEPTH x DATA_W register array, synchronous clear, byte-enabled write,
// asynchronous read.
//   clk   : clock (posedge)
//   rst_n : synchronous active-low clear of every register
//   we    : write enable
//   be    : per-byte write enables
//   widx  : write index, wdata : write data
//   ridx  : read index,  rdata : combinational read data
// ---------------------------------------------------------------------------
module apb_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
// APB slave exposing a DEPTH x DATA_W register array with WAIT_CYCLES
// wait states and PSLVERR on out-of-range or misaligned accesses.
//   pclk   : APB clock (posedge)
//   prst_n : synchronous active-low reset
//   bus    : apb_slave_mem_if.slave (psel, pen, paddr, pwrite, pwdata,
//            pstrb in; prdata, pready, pslverr out)
// Build option: APB_PSTRB_EN -- when defined, writes honour pstrb byte
// strobes; otherwise pstrb is ignored and writes update every byte.
//
// state  | meaning
// IDLE   | waiting for SETUP (psel=1, pen=0); request captured on entry
// ACCESS | wait counter running; completes when cnt==0, psel=1, pen=1
// ---------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              pclk,
    input  logic              prst_n,
    apb_slave_mem_if.slave    bus
);
    localparam int SHIFT = lane_shift(DATA_W);
    localparam int NBYTE = DATA_W / 8;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SHIFT) - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;

    logic              setup;
    logic              access_done;
    logic [ADDR_W-1:0] idx;
    logic              err;
    logic [NBYTE-1:0]  be;
    logic [DATA_W-1:0] rd_data;

    assign setup = bus.psel & ~bus.pen;

    // State register and wait counter.
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. psel=1 with pen=1 in IDLE is not a SETUP and is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bus.pen) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture: the master may change paddr/pwdata during ACCESS.
`ifdef APB_PSTRB_EN
    logic [NBYTE-1:0] pstrb_q;
`else
    logic unused_pstrb;
    assign unused_pstrb = ^bus.pstrb;
`endif

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
`ifdef APB_PSTRB_EN
            pstrb_q  <= '0;
`endif
        end else if (state_q == IDLE && setup) begin
            paddr_q  <= bus.paddr;
            pwrite_q <= bus.pwrite;
            pwdata_q <= bus.pwdata;
`ifdef APB_PSTRB_EN
            pstrb_q  <= bus.pstrb;
`endif
        end
    end

`ifdef APB_PSTRB_EN
    assign be = pstrb_q;
`else
    assign be = '1;
`endif

    // Address decode on the captured address.
    assign idx = paddr_q >> SHIFT;
    assign err = ({1'b0, idx} >= DEPTH_W) || ((paddr_q & LOW_MASK) != '0);

    // Output logic.
    always_comb begin
        access_done = (state_q == ACCESS) && bus.psel && bus.pen && (cnt_q == '0);
        bus.pready  = access_done;
        bus.pslverr = (access_done && err) ? APB_SLVERR : APB_OKAY;
        bus.prdata  = (access_done && !pwrite_q && !err) ? rd_data : '0;
    end

    apb_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk   (pclk),
        .rst_n (prst_n),
        .we    (access_done && pwrite_q && !err),
        .be    (be),
        .widx  (idx[IDX_W-1:0]),
        .wdata (pwdata_q),
        .ridx  (idx[IDX_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_mem
// Randomised scoreboard bench for apb_slave_mem (DATA_W=32, DEPTH=16,
// WAIT_CYCLES=2). Stimulus pushes expected responses; a negedge monitor
// pops and compares whenever pready is high.
// ---------------------------------------------------------------------------
module tb_apb_slave_mem;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int WAIT   = 2;
`ifdef APB_PSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic pclk   = 1'b0;
    logic prst_n = 1'b0;
    always #5 pclk = ~pclk;

    apb_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_slave_mem #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .pclk   (pclk),
        .prst_n (prst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem_m [DEPTH];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: word-indexed array, byte-address rules applied directly.
    function automatic exp_t model_xfer(input logic [7:0] a, input logic w,
                                        input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   widx;
        widx    = int'(a) / 4;
        e.err   = (widx >= DEPTH) || (int'(a) % 4 != 0);
        e.rdata = 32'h0;
        e.cyc   = 0;
        if (!e.err) begin
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b] || !STRB_EN) mem_m[widx][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                e.rdata = mem_m[widx];
            end
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    endtask

    // Full transfer; the master scrambles paddr/pwdata/pstrb during ACCESS.
    task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s);
        exp_t e;
        int   k;
        bit   done;
        @(posedge pclk); #1;
        bus.psel   = 1'b1;
        bus.pen    = 1'b0;
        bus.paddr  = a;
        bus.pwrite = w;
        bus.pwdata = d;
        bus.pstrb  = s;
        e     = model_xfer(a, w, d, s);
        e.cyc = cyc + WAIT + 1;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        bus.pen    = 1'b1;
        bus.paddr  = 8'($urandom);
        bus.pwdata = $urandom;
        bus.pstrb  = 4'($urandom);
        k    = 0;
        done = 1'b0;
        while (!done && k <= WAIT + 4) begin
            @(negedge pclk);
            if (bus.pready === 1'b1) done = 1'b1;
            else k++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL xfer_timeout: addr %h got no pready, required pready within %0d cycles",
                     a, WAIT + 1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
    endtask

    // SETUP followed by nacc access cycles, then psel dropped before completion.
    task automatic abort_xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                              input int nacc);
        @(posedge pclk); #1;
        bus.psel   = 1'b1;
        bus.pen    = 1'b0;
        bus.paddr  = a;
        bus.pwrite = w;
        bus.pwdata = d;
        bus.pstrb  = 4'hF;
        for (int i = 0; i < nacc; i++) begin
            @(posedge pclk); #1;
            bus.pen = 1'b1;
        end
        @(posedge pclk); #1;
        bus.psel = 1'b0;
        bus.pen  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            bus.psel = 1'b0;
            bus.pen  = 1'b0;
        end
    endtask

    // Monitor: every pready pulse must match the oldest expectation.
    always @(negedge pclk) begin
        if (bus.pready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pready", {31'b0, bus.pready}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("prdata", bus.prdata, mon_e.rdata);
                chk("pslverr", {31'b0, bus.pslverr}, {31'b0, mon_e.err});
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        int          r;
        bus.psel   = 1'b0;
        bus.pen    = 1'b0;
        bus.paddr  = '0;
        bus.pwrite = 1'b0;
        bus.pwdata = '0;
        bus.pstrb  = '0;
        clear_model();
        repeat (3) @(posedge pclk);
        #1 prst_n = 1'b1;
        @(negedge pclk);
        chk("reset_pready", {31'b0, bus.pready}, 32'h0);
        chk("reset_pslverr", {31'b0, bus.pslverr}, 32'h0);
        chk("reset_prdata", bus.prdata, 32'h0);

        // Write/read back-to-back, out-of-range read, misaligned write.
        xfer(8'h08, 1'b1, 32'hDEADBEEF, 4'hF);
        xfer(8'h08, 1'b0, 32'h0, 4'hF);
        xfer(8'h40, 1'b0, 32'h0, 4'hF);
        xfer(8'h00, 1'b0, 32'h0, 4'hF);
        xfer(8'h04, 1'b1, 32'h13579BDF, 4'hF);
        xfer(8'h06, 1'b1, 32'hFFFFFFFF, 4'hF);
        xfer(8'h04, 1'b0, 32'h0, 4'hF);
        idle(2);

        // Aborted write to 0x0C must not commit.
        abort_xfer(8'h0C, 1'b1, 32'hCAFEF00D, WAIT);
        xfer(8'h0C, 1'b0, 32'h0, 4'hF);

        // psel+pen straight from IDLE is ignored: no pready, no write.
        @(posedge pclk); #1;
        bus.psel   = 1'b1;
        bus.pen    = 1'b1;
        bus.paddr  = 8'h08;
        bus.pwrite = 1'b1;
        bus.pwdata = 32'h55555555;
        repeat (WAIT + 3) @(posedge pclk);
        idle(1);
        xfer(8'h08, 1'b0, 32'h0, 4'hF);

        // Reset one cycle after SETUP of a write to 0x10.
        @(posedge pclk); #1;
        bus.psel   = 1'b1;
        bus.pen    = 1'b0;
        bus.paddr  = 8'h10;
        bus.pwrite = 1'b1;
        bus.pwdata = 32'h87654321;
        @(posedge pclk); #1;
        prst_n  = 1'b0;
        bus.pen = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        chk("rst_mid_pready", {31'b0, bus.pready}, 32'h0);
        chk("rst_mid_pslverr", {31'b0, bus.pslverr}, 32'h0);
        chk("rst_mid_prdata", bus.prdata, 32'h0);
        @(posedge pclk); #1;
        prst_n   = 1'b1;
        bus.psel = 1'b0;
        bus.pen  = 1'b0;
        clear_model();
        xfer(8'h10, 1'b0, 32'h0, 4'hF);
        xfer(8'h08, 1'b0, 32'h0, 4'hF);

`ifdef APB_PSTRB_EN
        xfer(8'h14, 1'b1, 32'hAABBCCDD, 4'b1111);
        xfer(8'h14, 1'b1, 32'h11223344, 4'b0101);
        xfer(8'h14, 1'b0, 32'h0, 4'b0000);
        xfer(8'h14, 1'b1, 32'hFFFFFFFF, 4'b0000);
        xfer(8'h14, 1'b0, 32'h0, 4'b1111);
`endif

        // Randomised traffic, mostly aligned, with aborts and idle gaps.
        for (int n = 0; n < 300; n++) begin
            a = 8'($urandom_range(0, 8'h4F));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = $urandom;
            r = $urandom_range(0, 19);
            if (r == 0) abort_xfer(a, 1'b1, d, $urandom_range(0, WAIT));
            else if (r == 1) idle($urandom_range(1, 3));
            else xfer(a, 1'($urandom_range(0, 1)), d, 4'($urandom));
        end

        idle(WAIT + 4);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
